// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop sync, per-channel glitch filter, x1/x2/x4 step decode, position and error counters.
// Latency: raw edge captured at edge k updates value/step/dir at edge k+FILTER+2.
// Backpressure: none; free-running, every clock samples the inputs and may update the outputs.
module quad_decoder #(
  parameter int WIDTH    = 16,
  parameter int FILTER   = 4,
  parameter int SATURATE = 0,
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_err,
  output logic [WIDTH-1:0] value,
  output logic             dir,
  output logic             step,
  output logic             error,
  output logic             err_sticky,
  output logic [ERRW-1:0]  err_count
);

  localparam int CNTW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int BLKW = $clog2(FILTER + 4);
  localparam logic [BLKW-1:0] BLANK_INIT = BLKW'(FILTER + 3);
  localparam logic [CNTW-1:0] RUN_LAST   = CNTW'(FILTER - 1);
  localparam bit SAT = (SATURATE != 0);

  logic s1a_q, s1a_d, sa_q, sa_d, s1b_q, s1b_d, sb_q, sb_d;
  logic fa_q, fa_d, fb_q, fb_d;
  logic [CNTW-1:0] runa_q, runa_d, runb_q, runb_d;
  logic oa_q, oa_d, ob_q, ob_d;
  logic [BLKW-1:0] blank_q, blank_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic dir_q, dir_d, step_q, step_d, error_q, error_d, err_sticky_q, err_sticky_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  logic [1:0] prev_pos, cur_pos, delta;
  logic       cnt_ok, decode_en, count_up, count_dn, bad;
  logic [ERRW-1:0] err_base;

  // Synchronizers and glitch filters: a level is accepted after FILTER consecutive disagreeing samples.
  always_comb begin
    s1a_d  = a;
    sa_d   = s1a_q;
    s1b_d  = b;
    sb_d   = s1b_q;
    fa_d   = fa_q;
    runa_d = runa_q;
    fb_d   = fb_q;
    runb_d = runb_q;
    if (sa_q == fa_q) begin
      runa_d = '0;
    end else if (runa_q == RUN_LAST) begin
      fa_d   = sa_q;
      runa_d = '0;
    end else begin
      runa_d = runa_q + CNTW'(1);
    end
    if (sb_q == fb_q) begin
      runb_d = '0;
    end else if (runb_q == RUN_LAST) begin
      fb_d   = sb_q;
      runb_d = '0;
    end else begin
      runb_d = runb_q + CNTW'(1);
    end
  end

  // Transition decode: map AB onto a 2-bit cycle position so CW is +1, CCW is -1, +2 is illegal.
  always_comb begin
    prev_pos  = {ob_q, oa_q ^ ob_q};
    cur_pos   = {fb_q, fa_q ^ fb_q};
    delta     = cur_pos - prev_pos;
    decode_en = (blank_q == '0);
    case (res)
      2'b00:   cnt_ok = !ob_q && !fb_q;   // only the 00<->10 A edge
      2'b01:   cnt_ok = (oa_q != fa_q);   // any A edge
      default: cnt_ok = 1'b1;
    endcase
    count_up = decode_en && (delta == 2'd1) && cnt_ok;
    count_dn = decode_en && (delta == 2'd3) && cnt_ok;
    bad      = decode_en && (delta == 2'd2);
  end

  // Position, step/dir, error bookkeeping and post-reset blanking countdown.
  always_comb begin
    oa_d    = fa_q;
    ob_d    = fb_q;
    blank_d = (blank_q != '0) ? blank_q - BLKW'(1) : blank_q;
    value_d = value_q;
    if (count_up && !(SAT && value_q == '1)) begin
      value_d = value_q + WIDTH'(1);
    end else if (count_dn && !(SAT && value_q == '0)) begin
      value_d = value_q - WIDTH'(1);
    end
    if (load) begin
      value_d = load_value;
    end
    step_d = count_up || count_dn;
    dir_d  = count_up ? 1'b1 : (count_dn ? 1'b0 : dir_q);
    error_d = bad;
    err_base     = clr_err ? '0 : err_count_q;
    err_sticky_d = bad || (err_sticky_q && !clr_err);
    err_count_d  = err_base;
    if (bad && err_base != '1) begin
      err_count_d = err_base + ERRW'(1);
    end
  end

  // State registers; reset has priority over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1a_q <= 1'b0; sa_q <= 1'b0; s1b_q <= 1'b0; sb_q <= 1'b0;
      fa_q <= 1'b0; fb_q <= 1'b0; runa_q <= '0; runb_q <= '0;
      oa_q <= 1'b0; ob_q <= 1'b0;
      blank_q <= BLANK_INIT;
      value_q <= '0; dir_q <= 1'b0; step_q <= 1'b0; error_q <= 1'b0;
      err_sticky_q <= 1'b0; err_count_q <= '0;
    end else begin
      s1a_q <= s1a_d; sa_q <= sa_d; s1b_q <= s1b_d; sb_q <= sb_d;
      fa_q <= fa_d; fb_q <= fb_d; runa_q <= runa_d; runb_q <= runb_d;
      oa_q <= oa_d; ob_q <= ob_d;
      blank_q <= blank_d;
      value_q <= value_d; dir_q <= dir_d; step_q <= step_d; error_q <= error_d;
      err_sticky_q <= err_sticky_d; err_count_q <= err_count_d;
    end
  end

  assign value      = value_q;
  assign dir        = dir_q;
  assign step       = step_q;
  assign error      = error_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: a wrapping and a saturating instance share stimulus,
// checked against a position/step model driven from the quadrature rules.
module tb_quad_decoder;
  logic       clk = 1'b0;
  logic       reset, a, b, load, clr_err;
  logic [1:0] res;
  logic [7:0] lv;
  logic [7:0] v0, v1, ec0, ec1;
  logic       dir0, dir1, st0, st1, er0, er1, sk0, sk1;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int   mv0, mv1, mec;
  bit   msk, mdir;
  logic cur_a, cur_b;
  logic pa [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic pb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(8), .FILTER(4), .SATURATE(0), .ERRW(8)) u_wrap (
    .clk(clk), .reset(reset), .a(a), .b(b), .res(res), .load(load), .load_value(lv),
    .clr_err(clr_err), .value(v0), .dir(dir0), .step(st0), .error(er0),
    .err_sticky(sk0), .err_count(ec0));

  quad_decoder #(.WIDTH(8), .FILTER(4), .SATURATE(1), .ERRW(8)) u_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .res(res), .load(load), .load_value(lv),
    .clr_err(clr_err), .value(v1), .dir(dir1), .step(st1), .error(er1),
    .err_sticky(sk1), .err_count(ec1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // position of an AB state along the CW cycle 00,10,11,01
  function automatic int gpos(input logic xa, input logic xb);
    if (!xa && !xb) return 0;
    if (xa && !xb)  return 1;
    if (xa && xb)   return 2;
    return 3;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, "_v0"}, 32'(v0), 32'(mv0));
    chk({tag, "_v1"}, 32'(v1), 32'(mv1));
    chk({tag, "_dir0"}, 32'(dir0), 32'(mdir));
    chk({tag, "_dir1"}, 32'(dir1), 32'(mdir));
    chk({tag, "_ec"}, 32'(ec0), 32'(mec));
    chk({tag, "_sk"}, 32'(sk0), 32'(msk));
  endtask

  // Drive new raw AB, hold it, and check outputs exactly 6 edges after capture.
  task automatic move(input logic na, input logic nb, input bit do_load,
                      input logic [7:0] lval, input bit do_clr);
    int  pd;
    bit  legal, counted, illegal;
    pd      = (gpos(na, nb) - gpos(cur_a, cur_b)) & 3;
    legal   = (pd == 1) || (pd == 3);
    illegal = (pd == 2);
    case (res)
      2'b00:   counted = legal && !cur_b && !nb;
      2'b01:   counted = legal && (na != cur_a);
      default: counted = legal;
    endcase
    if (counted) begin
      mdir = (pd == 1);
      mv0  = (mv0 + ((pd == 1) ? 1 : -1)) & 255;
      mv1  = mv1 + ((pd == 1) ? 1 : -1);
      if (mv1 < 0)   mv1 = 0;
      if (mv1 > 255) mv1 = 255;
    end
    if (do_load) begin
      mv0 = lval;
      mv1 = lval;
    end
    if (illegal) begin
      mec = do_clr ? 1 : ((mec < 255) ? mec + 1 : 255);
      msk = 1'b1;
    end else if (do_clr) begin
      mec = 0;
      msk = 1'b0;
    end
    a = na; b = nb; cur_a = na; cur_b = nb;
    repeat (6) tick();
    chk("early_step", 32'(st0 | st1), 32'd0);
    chk("early_err", 32'(er0), 32'd0);
    if (do_load) begin load = 1'b1; lv = lval; end
    if (do_clr) clr_err = 1'b1;
    tick();
    load = 1'b0; clr_err = 1'b0;
    chk("step0", 32'(st0), 32'(counted));
    chk("step1", 32'(st1), 32'(counted));
    chk("error", 32'(er0), 32'(illegal));
    chk_all("move");
    repeat (4) tick();
  endtask

  task automatic stepdir(input int d);
    int p;
    p = (gpos(cur_a, cur_b) + d) & 3;
    move(pa[p], pb[p], 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_load(input logic [7:0] lval);
    lv = lval; load = 1'b1;
    tick();
    load = 1'b0;
    mv0 = lval; mv1 = lval;
    chk("load_v0", 32'(v0), 32'(lval));
    chk("load_v1", 32'(v1), 32'(lval));
  endtask

  task automatic quiet(input int n, input string tag);
    int s, e;
    s = 0; e = 0;
    repeat (n) begin
      tick();
      s += int'(st0) + int'(st1);
      e += int'(er0) + int'(er1);
    end
    chk({tag, "_steps"}, 32'(s), 32'd0);
    chk({tag, "_errs"}, 32'(e), 32'd0);
  endtask

  initial begin
    reset = 1'b1; a = 1'b0; b = 1'b0; res = 2'b10; load = 1'b0; lv = 8'h00; clr_err = 1'b0;
    cur_a = 1'b0; cur_b = 1'b0; mv0 = 0; mv1 = 0; mec = 0; msk = 1'b0; mdir = 1'b0;
    repeat (3) tick();
    chk("rst_step", 32'(st0), 32'd0);
    chk("rst_error", 32'(er0), 32'd0);
    chk_all("rst");
    reset = 1'b0;
    quiet(10, "blank0");

    // full CW cycle in x4
    res = 2'b10;
    stepdir(1); stepdir(1); stepdir(1); stepdir(1);
    chk("x4_cw_value", 32'(v0), 32'd4);

    // x1 and x2: two CW cycles, one CCW cycle
    res = 2'b00;
    do_load(8'd0);
    repeat (8) stepdir(1);
    repeat (4) stepdir(-1);
    chk("x1_value", 32'(v0), 32'd1);
    res = 2'b01;
    do_load(8'd0);
    repeat (8) stepdir(1);
    repeat (4) stepdir(-1);
    chk("x2_value", 32'(v0), 32'd2);

    // glitch shorter than the filter is discarded, a longer one counts
    res = 2'b10;
    a = 1'b1;
    repeat (3) tick();
    a = 1'b0;
    quiet(15, "glitch");
    chk("glitch_value", 32'(v0), 32'(mv0));
    move(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    stepdir(-1);

    // underflow: wrap vs clamp
    do_load(8'd0);
    stepdir(-1);
    chk("under_wrap", 32'(v0), 32'd255);
    chk("under_sat", 32'(v1), 32'd0);
    chk("under_dir", 32'(dir1), 32'd0);
    do_load(8'd255);
    stepdir(1);
    chk("over_wrap", 32'(v0), 32'd0);
    chk("over_sat", 32'(v1), 32'd255);

    // illegal transition, clear, clear racing an error, load racing a step
    stepdir(2);
    chk("illegal_cnt", 32'(ec0), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    mec = 0; msk = 1'b0;
    chk_all("clr");
    stepdir(2);
    stepdir(2);
    move(~cur_a, ~cur_b, 1'b0, 8'h00, 1'b1);
    chk("clr_race_cnt", 32'(ec0), 32'd1);
    move(cur_a ^ cur_b ? cur_a : ~cur_a, cur_a ^ cur_b ? ~cur_b : cur_b, 1'b1, 8'h3c, 1'b0);
    chk("load_race", 32'(v0), 32'h3c);

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      a = ~a; b = ~b;
      mec = (mec < 255) ? mec + 1 : 255;
      repeat (8) tick();
    end
    msk = 1'b1;
    repeat (8) tick();
    chk_all("err_sat");

    // randomized walk
    for (int i = 0; i < 60; i++) begin
      int r, d;
      r = $urandom_range(0, 9);
      d = (r < 4) ? 1 : (r < 7) ? -1 : (r == 7) ? 0 : 2;
      if ($urandom_range(0, 4) == 0) res = 2'($urandom_range(0, 3));
      begin
        int p;
        p = (gpos(cur_a, cur_b) + d) & 3;
        move(pa[p], pb[p], $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 9) == 0);
      end
    end

    // reset wins over load/clr, then blanking with raw inputs at 11
    reset = 1'b1; load = 1'b1; lv = 8'h55; clr_err = 1'b1; a = 1'b1; b = 1'b1;
    tick();
    load = 1'b0; clr_err = 1'b0;
    mv0 = 0; mv1 = 0; mec = 0; msk = 1'b0; mdir = 1'b0;
    chk("rst_prio_step", 32'(st0), 32'd0);
    chk_all("rst_prio");
    repeat (2) tick();
    reset = 1'b0;
    cur_a = 1'b1; cur_b = 1'b1;
    quiet(15, "blank11");
    chk_all("blank11");
    res = 2'b10;
    stepdir(1);
    chk("after_blank", 32'(v0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
